// File: rtl/dar_master_pkg.sv
// Shared definitions for the burst master, its register bank and the bench.
package dar_master_pkg;

    // Default bank geometry: 128 x 8.
    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 8;

    // Controller states.
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWrite = 3'd1;
    localparam logic [2:0] StRead  = 3'd2;
    localparam logic [2:0] StRhold = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/dar_master.sv
// Burst master for a single-port register bank: executes one write or read
// burst per command, with valid/ready handshakes on the command, write-data
// and read-data sides.
module dar_master
    import dar_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              bank_w_en,
    output logic              bank_r_en,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: cnt_q holds beats remaining minus one; address wraps.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (wdata_valid) begin
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                    end
                end
            end
            StRead: begin
                rdata_d = bank_rdata;
                state_d = StRhold;
            end
            StRhold: begin
                if (rdata_ready) begin
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode; the bank address is only driven during an access.
    always_comb begin
        cmd_ready   = (state_q == StIdle);
        wdata_ready = (state_q == StWrite);
        bank_w_en   = (state_q == StWrite) && wdata_valid;
        bank_r_en   = (state_q == StRead);
        rdata_valid = (state_q == StRhold);
        done        = (state_q == StDone);
        busy        = (state_q != StIdle);
        bank_addr   = (bank_w_en || bank_r_en) ? addr_q : '0;
        bank_wdata  = wdata;
        rdata       = rdata_q;
    end

endmodule
